// File: rtl/ft245_frame_receiver_pkg.sv
// Shared types and constants for the FT245 frame receiver.
// The helpers classify header bytes and map a byte index to a chunk index.
package ft245_frame_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_LOW  = 2'd1,
      ST_RD_HIGH = 2'd2
   } rd_state_e;

   localparam logic [1:0] HEADER_TAG       = 2'b10;
   localparam int         CHUNKS_PER_ROW   = 16;
   localparam int         BYTES_PER_CHUNK  = 4;
   localparam int         FRAME_DATA_BYTES = CHUNKS_PER_ROW * BYTES_PER_CHUNK;

   function automatic logic header_valid(input logic [7:0] hdr);
      return (hdr[7:6] == HEADER_TAG);
   endfunction

   // Data bytes are numbered 1..64, so byte n belongs to chunk (n-1)/4.
   function automatic logic [3:0] chunk_of_byte(input logic [6:0] idx);
      return 4'((idx - 7'd1) >> 2);
   endfunction

endpackage

// File: rtl/ft245_frame_receiver_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Its reset value is a parameter so idle-high flags come out of reset inactive.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Metastability chain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ft245_frame_receiver.sv
// Reads 65-byte frames from an FT245 FIFO and emits 32-bit chunk writes.
// It drives the read strobe, checks the header, packs pixel data and detects stalled frames.
module ft245_frame_receiver
   import ft245_frame_receiver_pkg::*;
#(
   parameter int RD_LOW_CYCLES  = 3,
   parameter int RD_HIGH_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxf_n_raw,
   input  logic [7:0]  data_bus_raw,
   output logic        rd_n,
   output logic        wr_n,
   output logic [31:0] chunk_data,
   output logic [3:0]  chunk_addr,
   output logic        chunk_write_enable,
   output logic [3:0]  row_data_row_addr,
   output logic [1:0]  row_data_panel_addr,
   output logic        frame_done,
   output logic        frame_error
);

   localparam int PH_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PH_W-1:0] RD_LOW_LAST  = PH_W'(RD_LOW_CYCLES - 1);
   localparam logic [PH_W-1:0] RD_HIGH_LAST = PH_W'(RD_HIGH_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LIMIT     = TO_W'(TIMEOUT_CYCLES);
   localparam logic [6:0]      LAST_IDX     = 7'(FRAME_DATA_BYTES);

   logic            rxf_n_s;
   rd_state_e       state_q, state_d;
   logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
   logic            sample_s;
   logic            rd_n_q;
   logic [7:0]      byte_q;
   logic            byte_vld_q;

   logic [6:0]      idx_q, idx_d;
   logic [23:0]     word_q, word_d;
   logic [31:0]     chunk_data_q, chunk_data_d;
   logic [3:0]      chunk_addr_q, chunk_addr_d;
   logic            cwe_q, cwe_d;
   logic [3:0]      row_q, row_d;
   logic [1:0]      panel_q, panel_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   sync_2ff #(
      .WIDTH    (1),
      .RESET_VAL(1'b1)
   ) u_rxf_sync (
      .clk_i(clk),
      .rst_i(reset),
      .d_i  (rxf_n_raw),
      .q_o  (rxf_n_s)
   );

   // Read strobe sequencer: once started, a read always runs both phases.
   always_comb begin
      state_d  = state_q;
      ph_cnt_d = ph_cnt_q;
      sample_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxf_n_s) begin
               state_d  = ST_RD_LOW;
               ph_cnt_d = '0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RD_LOW: begin
            if (ph_cnt_q == RD_LOW_LAST) begin
               state_d  = ST_RD_HIGH;
               ph_cnt_d = '0;
               sample_s = 1'b1;
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         ST_RD_HIGH: begin
            if (ph_cnt_q == RD_HIGH_LAST) begin
               state_d  = ST_IDLE;
               ph_cnt_d = '0;
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            ph_cnt_d = '0;
         end
      endcase
   end

   // Sequencer state, registered strobe and byte capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ph_cnt_q   <= '0;
         rd_n_q     <= 1'b1;
         byte_q     <= 8'h00;
         byte_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_cnt_q   <= ph_cnt_d;
         rd_n_q     <= (state_d != ST_RD_LOW);
         byte_vld_q <= sample_s;
         if (sample_s) begin
            byte_q <= data_bus_raw;
         end
      end
   end

   // Frame assembly: header hunt, big-endian packing and idle timeout.
   always_comb begin
      idx_d        = idx_q;
      word_d       = word_q;
      chunk_data_d = chunk_data_q;
      chunk_addr_d = chunk_addr_q;
      cwe_d        = 1'b0;
      row_d        = row_q;
      panel_d      = panel_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      to_cnt_d     = to_cnt_q;
      if (byte_vld_q) begin
         to_cnt_d = '0;
         if (idx_q == 7'd0) begin
            if (header_valid(byte_q)) begin
               row_d   = byte_q[3:0];
               panel_d = byte_q[5:4];
               idx_d   = 7'd1;
               word_d  = 24'h000000;
            end else begin
               err_d   = 1'b1;
            end
         end else begin
            word_d = {word_q[15:0], byte_q};
            if (idx_q[1:0] == 2'b00) begin
               chunk_data_d = {word_q, byte_q};
               chunk_addr_d = chunk_of_byte(idx_q);
               cwe_d        = 1'b1;
               if (idx_q == LAST_IDX) begin
                  done_d = 1'b1;
                  idx_d  = 7'd0;
               end else begin
                  idx_d  = idx_q + 7'd1;
               end
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
      end else if ((idx_q != 7'd0) && (state_q == ST_IDLE)) begin
         // to_cnt_q holds the number of idle cycles already seen before this one.
         if (to_cnt_q == TO_LIMIT) begin
            err_d    = 1'b1;
            idx_d    = 7'd0;
            word_d   = 24'h000000;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   // Frame state and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q        <= 7'd0;
         word_q       <= 24'h000000;
         chunk_data_q <= 32'h00000000;
         chunk_addr_q <= 4'd0;
         cwe_q        <= 1'b0;
         row_q        <= 4'd0;
         panel_q      <= 2'd0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         idx_q        <= idx_d;
         word_q       <= word_d;
         chunk_data_q <= chunk_data_d;
         chunk_addr_q <= chunk_addr_d;
         cwe_q        <= cwe_d;
         row_q        <= row_d;
         panel_q      <= panel_d;
         done_q       <= done_d;
         err_q        <= err_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign rd_n                = rd_n_q;
   assign wr_n                = 1'b1;
   assign chunk_data          = chunk_data_q;
   assign chunk_addr          = chunk_addr_q;
   assign chunk_write_enable  = cwe_q;
   assign row_data_row_addr   = row_q;
   assign row_data_panel_addr = panel_q;
   assign frame_done          = done_q;
   assign frame_error         = err_q;

endmodule

// File: tb/tb_ft245_frame_receiver.sv
// Directed bench: a behavioural FT245 feeds frames; a negedge monitor logs strobes and rd_n timing.
module tb_ft245_frame_receiver;

   localparam int TO_CYC = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxf_n_raw = 1'b1;
   logic [7:0]  data_bus_raw = 8'h00;
   logic        rd_n, wr_n;
   logic [31:0] chunk_data;
   logic [3:0]  chunk_addr;
   logic        chunk_write_enable;
   logic [3:0]  row_data_row_addr;
   logic [1:0]  row_data_panel_addr;
   logic        frame_done, frame_error;

   int n_assert = 0;
   int n_fail   = 0;

   int          cyc = 0;
   logic        prev_rd = 1'b1;
   int          fall_cyc = 0, rise_cyc = 0;
   logic        have_rise = 1'b0;
   int          rd_count = 0, low_bad = 0, high_bad = 0;
   int          n_chunks = 0, fd_count = 0, fd_bad = 0, fe_count = 0;
   logic [31:0] chunk_log [0:511];
   logic [3:0]  addr_log  [0:511];

   ft245_frame_receiver #(
      .RD_LOW_CYCLES (3),
      .RD_HIGH_CYCLES(4),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .rxf_n_raw          (rxf_n_raw),
      .data_bus_raw       (data_bus_raw),
      .rd_n               (rd_n),
      .wr_n               (wr_n),
      .chunk_data         (chunk_data),
      .chunk_addr         (chunk_addr),
      .chunk_write_enable (chunk_write_enable),
      .row_data_row_addr  (row_data_row_addr),
      .row_data_panel_addr(row_data_panel_addr),
      .frame_done         (frame_done),
      .frame_error        (frame_error)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      prev_rd <= rd_n;
      if (prev_rd && !rd_n) begin
         rd_count <= rd_count + 1;
         fall_cyc <= cyc;
         if (have_rise && ((cyc - rise_cyc) < 4)) high_bad <= high_bad + 1;
      end
      if (!prev_rd && rd_n) begin
         rise_cyc  <= cyc;
         have_rise <= 1'b1;
         if ((cyc - fall_cyc) != 3) low_bad <= low_bad + 1;
      end
      if (chunk_write_enable) begin
         chunk_log[n_chunks] <= chunk_data;
         addr_log[n_chunks]  <= chunk_addr;
         n_chunks            <= n_chunks + 1;
      end
      if (frame_done) begin
         fd_count <= fd_count + 1;
         if (!chunk_write_enable || (chunk_addr != 4'd15)) fd_bad <= fd_bad + 1;
      end
      if (frame_error) fe_count <= fe_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ft_byte(input logic [7:0] b);
      int w;
      @(negedge clk);
      rxf_n_raw    = 1'b0;
      data_bus_raw = b;
      w = 0;
      while (rd_n !== 1'b0 && w < 50) begin @(negedge clk); w++; end
      check("rd_fall_wait", 32'(w < 50), 32'd1);
      w = 0;
      while (rd_n !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      rxf_n_raw = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_bytes(input logic [7:0] first, input logic [7:0] step, input int n);
      logic [7:0] b;
      b = first;
      for (int i = 0; i < n; i++) begin
         ft_byte(b);
         b = b + step;
      end
   endtask

   task automatic check_frame(input string tag, input int base, input logic [1:0] panel,
                              input logic [3:0] row, input logic [7:0] first, input logic [7:0] step);
      logic [7:0]  b;
      logic [31:0] exp;
      int          bad;
      bad = 0;
      b = first;
      for (int k = 0; k < 16; k++) begin
         exp = 32'h0;
         for (int j = 0; j < 4; j++) begin
            exp = {exp[23:0], b};
            b   = b + step;
         end
         if (chunk_log[base + k] !== exp || addr_log[base + k] !== 4'(k)) bad++;
      end
      check({tag, "_chunk_count"}, 32'(n_chunks - base), 32'd16);
      check({tag, "_chunk_contents"}, 32'(bad), 32'd0);
      check({tag, "_panel"}, {30'd0, row_data_panel_addr}, {30'd0, panel});
      check({tag, "_row"}, {28'd0, row_data_row_addr}, {28'd0, row});
   endtask

   initial begin
      int c0, f0, e0, r0, l0, d0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rd_n", {31'd0, rd_n}, 32'd1);
      check("rst_wr_n", {31'd0, wr_n}, 32'd1);
      check("rst_chunk_data", chunk_data, 32'h0);
      check("rst_addrs", {22'd0, chunk_addr, row_data_row_addr, row_data_panel_addr}, 32'd0);
      check("rst_strobes", {29'd0, chunk_write_enable, frame_done, frame_error}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_no_read", 32'(rd_count), 32'd0);

      // Frame 1: header 9A, data 00..3F
      c0 = n_chunks; f0 = fd_count; e0 = fe_count; r0 = rd_count;
      ft_byte(8'h9A);
      send_bytes(8'h00, 8'h01, 64);
      check_frame("f1", c0, 2'd1, 4'hA, 8'h00, 8'h01);
      check("f1_chunk0", chunk_log[c0], 32'h00010203);
      check("f1_chunk15", chunk_log[c0 + 15], 32'h3C3D3E3F);
      check("f1_hold_data", chunk_data, 32'h3C3D3E3F);
      check("f1_hold_addr", {28'd0, chunk_addr}, 32'd15);
      check("f1_frame_done", 32'(fd_count - f0), 32'd1);
      check("f1_done_with_last", 32'(fd_bad), 32'd0);
      check("f1_no_error", 32'(fe_count - e0), 32'd0);
      check("f1_reads", 32'(rd_count - r0), 32'd65);
      check("f1_low_width", 32'(low_bad), 32'd0);
      check("f1_high_width", 32'(high_bad), 32'd0);
      repeat (20) @(negedge clk);
      check("f1_no_extra_read", 32'(rd_count - r0), 32'd65);

      // Bad header 5A then a valid frame B5 with descending data
      c0 = n_chunks; f0 = fd_count; e0 = fe_count;
      ft_byte(8'h5A);
      repeat (3) @(negedge clk);
      check("bad_hdr_error", 32'(fe_count - e0), 32'd1);
      check("bad_hdr_no_chunk", 32'(n_chunks - c0), 32'd0);
      check("bad_hdr_row_held", {28'd0, row_data_row_addr}, 32'hA);
      ft_byte(8'hB5);
      send_bytes(8'hFF, 8'hFF, 64);
      check_frame("f2", c0, 2'd3, 4'h5, 8'hFF, 8'hFF);
      check("f2_chunk0", chunk_log[c0], 32'hFFFEFDFC);
      check("f2_chunk15", chunk_log[c0 + 15], 32'hC3C2C1C0);
      check("f2_frame_done", 32'(fd_count - f0), 32'd1);
      check("f2_error_once", 32'(fe_count - e0), 32'd1);

      // Stall after 10 data bytes
      c0 = n_chunks; f0 = fd_count; e0 = fe_count;
      ft_byte(8'h87);
      send_bytes(8'h10, 8'h01, 10);
      repeat (TO_CYC / 2) @(negedge clk);
      check("stall_early_no_error", 32'(fe_count - e0), 32'd0);
      repeat (TO_CYC) @(negedge clk);
      check("stall_timeout_error", 32'(fe_count - e0), 32'd1);
      check("stall_two_chunks", 32'(n_chunks - c0), 32'd2);
      check("stall_chunk1", chunk_log[c0 + 1], 32'h14151617);
      check("stall_no_done", 32'(fd_count - f0), 32'd0);
      check("stall_row", {28'd0, row_data_row_addr}, 32'h7);
      c0 = n_chunks;
      ft_byte(8'hA3);
      send_bytes(8'h40, 8'h01, 64);
      check_frame("f3", c0, 2'd2, 4'h3, 8'h40, 8'h01);
      check("f3_chunk15", chunk_log[c0 + 15], 32'h7C7D7E7F);
      check("f3_frame_done", 32'(fd_count - f0), 32'd1);

      // Reset during RD_LOW of data byte 30
      ft_byte(8'h9A);
      send_bytes(8'h00, 8'h01, 29);
      @(negedge clk);
      rxf_n_raw    = 1'b0;
      data_bus_raw = 8'h1D;
      l0 = 0;
      while (rd_n !== 1'b0 && l0 < 50) begin @(negedge clk); l0++; end
      check("rst_mid_rd_fall_wait", 32'(l0 < 50), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_rd_n", {31'd0, rd_n}, 32'd1);
      check("mid_rst_chunk_data", chunk_data, 32'h0);
      check("mid_rst_addrs", {22'd0, chunk_addr, row_data_row_addr, row_data_panel_addr}, 32'd0);
      check("mid_rst_strobes", {29'd0, chunk_write_enable, frame_done, frame_error}, 32'd0);
      rxf_n_raw = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      c0 = n_chunks; f0 = fd_count; e0 = fe_count; l0 = low_bad; d0 = high_bad;
      ft_byte(8'hBC);
      send_bytes(8'hA0, 8'h01, 64);
      check_frame("f4", c0, 2'd3, 4'hC, 8'hA0, 8'h01);
      check("f4_chunk0", chunk_log[c0], 32'hA0A1A2A3);
      check("f4_chunk15", chunk_log[c0 + 15], 32'hDCDDDEDF);
      check("f4_frame_done", 32'(fd_count - f0), 32'd1);
      check("f4_no_error", 32'(fe_count - e0), 32'd0);
      check("f4_low_width", 32'(low_bad - l0), 32'd0);
      check("f4_high_width", 32'(high_bad - d0), 32'd0);
      check("f4_done_with_last", 32'(fd_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ft245_frame_receiver.md
FT245_FRAME_RECEIVER -- requirements
Module: ft245_frame_receiver

Interface
REQ-001 Parameter RD_LOW_CYCLES, default 3: clk cycles rd_n is held low per byte read (FT245 RD pulse width at least 50 ns at 50 MHz).
REQ-002 Parameter RD_HIGH_CYCLES, default 4: clk cycles rd_n is held high after each read; SHALL be at least 4.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: maximum idle gap between bytes inside a frame.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rxf_n_raw  input  1  FT245 receive-data-available flag; asynchronous, active low.
REQ-008 data_bus_raw  input  8  FT245 data bus; asynchronous.
REQ-009 rd_n  output  1  FT245 read strobe, active low.
REQ-010 wr_n  output  1  FT245 write strobe; held at 1 at all times.
REQ-011 chunk_data  output  32  assembled chunk word.
REQ-012 chunk_addr  output  4  chunk index within the row, 0-15.
REQ-013 chunk_write_enable  output  1  one-cycle strobe that qualifies chunk_data and chunk_addr.
REQ-014 row_data_row_addr  output  4  row address of the current frame.
REQ-015 row_data_panel_addr  output  2  panel address of the current frame.
REQ-016 frame_done  output  1  one-cycle pulse on the final chunk of a frame.
REQ-017 frame_error  output  1  one-cycle pulse when a bad header byte is dropped or a frame times out.

Function
REQ-018 rxf_n_raw SHALL pass through a 2-flop synchronizer before any use.
REQ-019 FSM states and transitions:
- IDLE -> RD_LOW when the synchronized rxf_n is 0.
- RD_LOW -> RD_HIGH after RD_LOW_CYCLES cycles.
- RD_HIGH -> IDLE after RD_HIGH_CYCLES cycles.
REQ-020 rd_n SHALL be 0 exactly in RD_LOW, and registered (glitch-free).
REQ-021 data_bus_raw SHALL be registered on the final cycle of RD_LOW; that registered byte is the received byte.
REQ-022 Frame format: 65 bytes.
- Byte 0 is the header: header[7:6] must be 2'b10, header[5:4] is the panel address, header[3:0] is the row address.
- Bytes 1-64 are pixel data.
REQ-023 A header with header[7:6] != 2'b10 SHALL be discarded with a frame_error pulse; the block stays in header hunt.
REQ-024 A valid header SHALL load row_data_row_addr and row_data_panel_addr; both hold until the next valid header.
REQ-025 Data bytes SHALL pack big-endian: the first byte of each group of four lands in chunk_data[31:24].
REQ-026 On the 4th byte of chunk k:
- chunk_data, chunk_addr=k and chunk_write_enable=1 SHALL appear one cycle after the byte is sampled.
- chunk_data and chunk_addr hold until the next chunk.
REQ-027 For k=15, frame_done SHALL pulse in the same cycle as chunk_write_enable; the byte index then wraps to header hunt.
REQ-028 Inside a frame (byte index 1-64), more than TIMEOUT_CYCLES consecutive IDLE cycles SHALL:
- discard the partial chunk;
- pulse frame_error;
- return to header hunt.
REQ-029 The timeout counter SHALL clear on every sampled byte and SHALL be inactive during header hunt.
REQ-030 If rxf_n deasserts mid-frame, the FSM SHALL wait in IDLE; no frame state is lost unless REQ-028 fires.
REQ-031 A read that has started SHALL always complete its RD_LOW and RD_HIGH phases, even if rxf_n changes.

Reset
REQ-032 On reset:
- rd_n=1 and wr_n=1.
- FSM=IDLE, in header hunt.
- chunk_data=0, chunk_addr=0, row/panel addr=0.
- All strobes 0.
- Counters cleared and synchronizer flops set to 1.
REQ-033 Reset asserted mid-read SHALL raise rd_n asynchronously and discard the partial frame.

Structure
REQ-034 The shared package SHALL hold:
- the FSM state typedef;
- HEADER_TAG=2'b10;
- CHUNKS_PER_ROW=16 and BYTES_PER_CHUNK=4.
REQ-035 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, reusable for panel switches.

Verification
REQ-036 FT245 model: header 8'h9A followed by bytes 00..3F.
- Expect 16 strobes; chunk 0 = 32'h00010203; chunk 15 = 32'h3C3D3E3F.
- Expect panel=1, row=A and frame_done with chunk 15.
REQ-037 Measured rd_n pulses SHALL be exactly 3 cycles low with at least 4 cycles high, and never more than one read while rxf_n_raw stays high.
REQ-038 Header 8'h5A -> frame_error pulses, no chunk strobes; a following valid frame is received intact.
REQ-039 Stall after 10 data bytes for TIMEOUT_CYCLES+1 cycles -> frame_error, no third chunk; the next header is accepted.
REQ-040 Reset asserted during RD_LOW of byte 30 -> rd_n=1 immediately and outputs at reset values; a fresh frame then completes normally.
